game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//   Top-level round sequencer for the game. Drives the 4-bit state bus read by the player
//   life/money block and the spawners: 0 IDLE, 1-4 LEVEL1-4, 5 FAIL, 6 CLEAR.
//   Charges one ticket per run, times each level from an internal 1 s tick, reacts to the
//   player fail flag, and holds the result screens for a fixed time before returning to IDLE.
// PARAMETERS
//   TICK_CYCLES  100_000_000  clk cycles per 1 s tick (100 MHz clock)
//   LEVEL_SECS   30           level duration in seconds (1..99)
//   RESULT_SECS  3            FAIL/CLEAR hold time in seconds (1..99)
//   TICKET_COST  10           minimum total_money needed to start a run
// PORTS
//   clk          in   1  system clock
//   rst          in   1  asynchronous reset, active-high
//   start        in   1  debounced one-cycle start pulse
//   abort        in   1  debounced one-cycle pulse; quit to IDLE
//   fail         in   1  player fail flag (life exhausted)
//   total_money  in   7  player money, 0..99
//   state        out  4  game state (encoding above)
//   ticket       out  1  one-cycle pulse; player deducts one ticket
//   level_start  out  1  one-cycle pulse on entry to each level 1-4
//   play_en      out  1  1 while state is 1..4
//   sec_left     out  7  seconds remaining in current level or result screen
//   no_funds     out  1  one-cycle pulse when start is refused
// BEHAVIOUR
//   Reset: state=0, ticket=0, level_start=0, no_funds=0, sec_left=0, tick counter=0.
//   All outputs are registered except play_en, which is a decode of the state register.
//   Tick counter: counts 0..TICK_CYCLES-1 and wraps. tick=1 when count==TICK_CYCLES-1.
//     The counter clears to 0 on every state change, so each state starts with a full second.
//   Priority, highest first: rst > abort > fail > timer expiry > timer decrement.
//   IDLE (0):
//     start && total_money>=TICKET_COST -> state 1 next cycle, sec_left=LEVEL_SECS.
//       ticket=1 and level_start=1 for exactly that first cycle of state 1.
//     start && total_money<TICKET_COST -> stay in 0; no_funds=1 for one cycle; ticket stays 0.
//     abort in IDLE: no effect.
//   LEVELn (1-4):
//     abort -> 0, sec_left=0.
//     else fail -> 5, sec_left=RESULT_SECS. Fail wins even on the cycle the level expires.
//     else tick && sec_left==1:
//       n<4 -> n+1, sec_left=LEVEL_SECS, level_start pulse.
//       n==4 -> 6, sec_left=RESULT_SECS.
//     else tick -> sec_left-1.
//   FAIL (5) / CLEAR (6):
//     start and fail are ignored. abort -> 0.
//     tick && sec_left==1 -> 0, sec_left=0. else tick -> sec_left-1.
//   States 7-15 are unreachable. If entered, go to 0 on the next cycle with no pulses.
//   ticket, level_start and no_funds never stay high longer than one cycle and are never
//     asserted together with abort.
//   start arriving on the same cycle as abort: abort wins. From IDLE, start is honoured.
//   Async reset mid-run clears everything immediately, with no ticket refund.
// TESTING (bench params: TICK_CYCLES=4, LEVEL_SECS=3, RESULT_SECS=2, TICKET_COST=10)
//   1. money=20, pulse start in IDLE -> next cycle state=1, ticket=1 and level_start=1 for
//      1 cycle, sec_left=3, play_en=1.
//   2. money=9, pulse start -> state stays 0, no_funds=1 for 1 cycle, ticket never asserted.
//   3. Full run, fail=0 -> states 1,2,3,4 each last 12 cycles; state 6 lasts 8 cycles; then 0.
//      Exactly 4 level_start pulses and 1 ticket pulse.
//   4. In level 2, assert fail on the cycle of the expiring tick -> state=5 (not 3),
//      sec_left=2; 8 cycles later state=0.
//   5. abort in level 3 -> state=0 next cycle, sec_left=0. Start pulsed during FAIL is
//      ignored with no ticket pulse.
//   6. Assert rst mid level 4 between clock edges -> state=0, sec_left=0, play_en=0 at once.
//      A start after release re-charges the ticket.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
//   Round sequencer for the game. Publishes the game state on a 4-bit bus:
//   0 IDLE, 1-4 LEVEL1-4, 5 FAIL, 6 CLEAR. A run costs one ticket. Each level
//   is timed from an internal one-second tick. The player fail flag ends a run.
//   The FAIL and CLEAR screens are held for a fixed time, then the game
//   returns to IDLE.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   start        one-cycle start request (debounced)
//   abort        one-cycle quit request (debounced); returns to IDLE
//   fail         player fail flag (life exhausted)
//   total_money  player money, 0..99
//   state        game state (encoding above), registered
//   ticket       one-cycle pulse: player deducts one ticket
//   level_start  one-cycle pulse on entry to each of levels 1-4
//   play_en      high while state is 1..4 (decode of the state register)
//   sec_left     seconds remaining in the current level or result screen
//   no_funds     one-cycle pulse when a start is refused for lack of money
module game_flow_ctrl #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int LEVEL_SECS  = 30,
  parameter int RESULT_SECS = 3,
  parameter int TICKET_COST = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       fail,
  input  logic [6:0] total_money,
  output logic [3:0] state,
  output logic       ticket,
  output logic       level_start,
  output logic       play_en,
  output logic [6:0] sec_left,
  output logic       no_funds
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
  localparam logic [6:0]       LEVEL_SEC = 7'(LEVEL_SECS);
  localparam logic [6:0]       RESULT_SEC = 7'(RESULT_SECS);
  localparam logic [6:0]       COST      = 7'(TICKET_COST);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_L1    = 4'd1,
    S_L2    = 4'd2,
    S_L3    = 4'd3,
    S_L4    = 4'd4,
    S_FAIL  = 4'd5,
    S_CLEAR = 4'd6
  } state_t;

  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [6:0]       sec_r, sec_nx;
  logic             ticket_r, ticket_nx;
  logic             ls_r, ls_nx;
  logic             nf_r, nf_nx;
  logic             tick_s;
  logic             last_sec_s;
  logic             funded_s;

  assign tick_s     = (cnt_r == CNT_LAST);
  assign last_sec_s = (sec_r == 7'd1);
  assign funded_s   = (total_money >= COST);

  // Next-state, seconds-remaining and pulse decode.
  always_comb begin
    state_nx  = state_r;
    sec_nx    = sec_r;
    ticket_nx = 1'b0;
    ls_nx     = 1'b0;
    nf_nx     = 1'b0;
    case (state_r)
      S_IDLE: begin
        // An abort in IDLE has no effect, so a start arriving with it is still honoured.
        if (start) begin
          if (funded_s) begin
            state_nx  = S_L1;
            sec_nx    = LEVEL_SEC;
            ticket_nx = 1'b1;
            ls_nx     = 1'b1;
          end else begin
            nf_nx = 1'b1;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_L1, S_L2, S_L3, S_L4: begin
        if (abort) begin
          state_nx = S_IDLE;
          sec_nx   = 7'd0;
        end else if (fail) begin
          // Fail is checked before expiry so it wins on the level's last tick.
          state_nx = S_FAIL;
          sec_nx   = RESULT_SEC;
        end else if (tick_s && last_sec_s) begin
          if (state_r == S_L4) begin
            state_nx = S_CLEAR;
            sec_nx   = RESULT_SEC;
          end else begin
            state_nx = state_t'(state_r + 4'd1);
            sec_nx   = LEVEL_SEC;
            ls_nx    = 1'b1;
          end
        end else if (tick_s) begin
          sec_nx = sec_r - 7'd1;
        end else begin
          sec_nx = sec_r;
        end
      end
      S_FAIL, S_CLEAR: begin
        if (abort) begin
          state_nx = S_IDLE;
          sec_nx   = 7'd0;
        end else if (tick_s && last_sec_s) begin
          state_nx = S_IDLE;
          sec_nx   = 7'd0;
        end else if (tick_s) begin
          sec_nx = sec_r - 7'd1;
        end else begin
          sec_nx = sec_r;
        end
      end
      default: begin
        // Unreachable encodings recover to IDLE without pulses.
        state_nx = S_IDLE;
        sec_nx   = 7'd0;
      end
    endcase
  end

  // Second counter; restarts on every state change so each state gets full seconds.
  always_comb begin
    if (state_nx != state_r) begin
      cnt_nx = '0;
    end else if (tick_s) begin
      cnt_nx = '0;
    end else begin
      cnt_nx = cnt_r + CNT_W'(1);
    end
  end

  // State, timer and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      sec_r    <= 7'd0;
      ticket_r <= 1'b0;
      ls_r     <= 1'b0;
      nf_r     <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      sec_r    <= sec_nx;
      ticket_r <= ticket_nx;
      ls_r     <= ls_nx;
      nf_r     <= nf_nx;
    end
  end

  assign state       = state_r;
  assign sec_left    = sec_r;
  assign ticket      = ticket_r;
  assign level_start = ls_r;
  assign no_funds    = nf_r;
  assign play_en     = (state_r == S_L1) || (state_r == S_L2) ||
                       (state_r == S_L3) || (state_r == S_L4);

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  localparam int TICK = 4;
  localparam int LVL  = 3;
  localparam int RES  = 2;
  localparam int COST = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       fail;
  logic [6:0] total_money;
  logic [3:0] state;
  logic       ticket;
  logic       level_start;
  logic       play_en;
  logic [6:0] sec_left;
  logic       no_funds;

  int total = 0;
  int bad   = 0;

  // Reference model: game stage, seconds left, cycles spent in the current stage.
  int m_st, m_sec, m_age;
  bit m_ticket, m_ls, m_nf;

  game_flow_ctrl #(
    .TICK_CYCLES(TICK), .LEVEL_SECS(LVL), .RESULT_SECS(RES), .TICKET_COST(COST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fail(fail),
    .total_money(total_money), .state(state), .ticket(ticket),
    .level_start(level_start), .play_en(play_en), .sec_left(sec_left),
    .no_funds(no_funds)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_st = 0; m_sec = 0; m_age = 0;
    m_ticket = 0; m_ls = 0; m_nf = 0;
  endfunction

  // One clock of the game rules: a second elapses every TICK cycles spent in a stage.
  function automatic void model_step(input bit s, input bit a, input bit f, input int money);
    bit tick_now;
    int nst, nsec;
    tick_now = ((m_age % TICK) == TICK - 1);
    nst = m_st; nsec = m_sec;
    m_ticket = 0; m_ls = 0; m_nf = 0;
    if (m_st == 0) begin
      if (s && money >= COST) begin nst = 1; nsec = LVL; m_ticket = 1; m_ls = 1; end
      else if (s) m_nf = 1;
    end else if (m_st <= 4) begin
      if (a) begin nst = 0; nsec = 0; end
      else if (f) begin nst = 5; nsec = RES; end
      else if (tick_now) begin
        if (m_sec > 1) nsec = m_sec - 1;
        else if (m_st < 4) begin nst = m_st + 1; nsec = LVL; m_ls = 1; end
        else begin nst = 6; nsec = RES; end
      end
    end else begin
      if (a) begin nst = 0; nsec = 0; end
      else if (tick_now) begin
        if (m_sec > 1) nsec = m_sec - 1;
        else begin nst = 0; nsec = 0; end
      end
    end
    m_age = (nst != m_st) ? 0 : m_age + 1;
    m_st = nst; m_sec = nsec;
  endfunction

  function automatic logic [14:0] model_vec();
    bit pe;
    pe = (m_st >= 1 && m_st <= 4);
    return {4'(m_st), 7'(m_sec), m_ticket, m_ls, pe, m_nf};
  endfunction

  // Apply inputs for one clock, advance the model, land 1 time unit after the edge.
  task automatic cyc(input bit s, input bit a, input bit f);
    start = s; abort = a; fail = f;
    @(posedge clk);
    model_step(s, a, f, int'(total_money));
    #1;
    start = 1'b0; abort = 1'b0; fail = 1'b0;
  endtask

  task automatic wait_state(input int target);
    int g;
    g = 0;
    while (state != 4'(target) && g < 100) begin
      cyc(0, 0, 0);
      g++;
    end
    total++;
    if (state != 4'(target)) begin
      bad++;
      $display("FAIL wait_state: got %0d want %0d (timeout)", state, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (state !== 4'd0)    begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (sec_left !== 7'd0) begin bad++; $display("FAIL reset_sec: got %0d want 0", sec_left); end
    total++; if ({ticket, level_start, no_funds, play_en} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses: got %b want 0000", {ticket, level_start, no_funds, play_en});
    end
    #3 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_start_ok();
    total_money = 7'd20;
    cyc(1, 0, 0);
    total++; if (state !== 4'd1)    begin bad++; $display("FAIL start_state: got %0d want 1", state); end
    total++; if (ticket !== 1'b1)   begin bad++; $display("FAIL start_ticket: got %0d want 1", ticket); end
    total++; if (level_start !== 1'b1) begin bad++; $display("FAIL start_ls: got %0d want 1", level_start); end
    total++; if (sec_left !== 7'd3) begin bad++; $display("FAIL start_sec: got %0d want 3", sec_left); end
    total++; if (play_en !== 1'b1)  begin bad++; $display("FAIL start_play: got %0d want 1", play_en); end
    cyc(0, 0, 0);
    total++; if ({ticket, level_start} !== 2'b00) begin
      bad++; $display("FAIL start_pulse_len: got %b want 00", {ticket, level_start});
    end
    cyc(0, 1, 0);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL start_abort: got %0d want 0", state); end
  endtask

  task automatic test_no_funds();
    total_money = 7'd9;
    cyc(1, 0, 0);
    total++; if (state !== 4'd0)   begin bad++; $display("FAIL nofunds_state: got %0d want 0", state); end
    total++; if (no_funds !== 1'b1) begin bad++; $display("FAIL nofunds_pulse: got %0d want 1", no_funds); end
    total++; if (ticket !== 1'b0)  begin bad++; $display("FAIL nofunds_ticket: got %0d want 0", ticket); end
    cyc(0, 0, 0);
    total++; if ({no_funds, ticket} !== 2'b00) begin
      bad++; $display("FAIL nofunds_len: got %b want 00", {no_funds, ticket});
    end
  endtask

  task automatic test_full_run();
    int dur[16];
    int n_ls, n_tk, g;
    foreach (dur[i]) dur[i] = 0;
    n_ls = 0; n_tk = 0; g = 0;
    total_money = 7'd20;
    cyc(1, 0, 0);
    while (state != 4'd0 && g < 200) begin
      dur[state]++;
      n_ls += int'(level_start);
      n_tk += int'(ticket);
      total++;
      if ({state, sec_left, ticket, level_start, play_en, no_funds} !== model_vec()) begin
        bad++; $display("FAIL run_model: got %h want %h", {state, sec_left, ticket, level_start, play_en, no_funds}, model_vec());
      end
      cyc(0, 0, 0);
      g++;
    end
    for (int i = 1; i <= 4; i++) begin
      total++; if (dur[i] != 12) begin bad++; $display("FAIL run_len_l%0d: got %0d want 12", i, dur[i]); end
    end
    total++; if (dur[6] != 8) begin bad++; $display("FAIL run_len_clear: got %0d want 8", dur[6]); end
    total++; if (dur[5] != 0) begin bad++; $display("FAIL run_len_failstate: got %0d want 0", dur[5]); end
    total++; if (n_ls != 4)   begin bad++; $display("FAIL run_ls_count: got %0d want 4", n_ls); end
    total++; if (n_tk != 1)   begin bad++; $display("FAIL run_ticket_count: got %0d want 1", n_tk); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL run_end: got %0d want 0", state); end
  endtask

  task automatic test_fail_expire();
    total_money = 7'd20;
    cyc(1, 0, 0);
    wait_state(2);
    repeat (11) cyc(0, 0, 0);
    total++; if ({state, sec_left} !== {4'd2, 7'd1}) begin
      bad++; $display("FAIL expire_pre: got %0d/%0d want 2/1", state, sec_left);
    end
    cyc(0, 0, 1);
    total++; if (state !== 4'd5)    begin bad++; $display("FAIL expire_fail_state: got %0d want 5", state); end
    total++; if (sec_left !== 7'd2) begin bad++; $display("FAIL expire_fail_sec: got %0d want 2", sec_left); end
    total++; if (level_start !== 1'b0) begin bad++; $display("FAIL expire_no_ls: got %0d want 0", level_start); end
    repeat (7) cyc(0, 0, 0);
    total++; if (state !== 4'd5) begin bad++; $display("FAIL expire_hold: got %0d want 5", state); end
    cyc(0, 0, 0);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL expire_return: got %0d want 0", state); end
  endtask

  task automatic test_abort();
    total_money = 7'd20;
    cyc(1, 0, 0);
    wait_state(3);
    cyc(0, 1, 0);
    total++; if ({state, sec_left} !== {4'd0, 7'd0}) begin
      bad++; $display("FAIL abort_l3: got %0d/%0d want 0/0", state, sec_left);
    end
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    total++; if ({state, ticket} !== {4'd0, 1'b0}) begin
      bad++; $display("FAIL abort_with_start: got %0d/%0d want 0/0", state, ticket);
    end
    cyc(1, 1, 0);
    total++; if ({state, ticket} !== {4'd1, 1'b1}) begin
      bad++; $display("FAIL idle_start_abort: got %0d/%0d want 1/1", state, ticket);
    end
    cyc(0, 0, 1);
    total++; if (state !== 4'd5) begin bad++; $display("FAIL abort_to_fail: got %0d want 5", state); end
    cyc(1, 0, 0);
    total++; if ({state, ticket, level_start} !== {4'd5, 2'b00}) begin
      bad++; $display("FAIL start_in_failstate: got %0d/%0d/%0d want 5/0/0", state, ticket, level_start);
    end
    cyc(0, 1, 0);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL abort_result: got %0d want 0", state); end
  endtask

  task automatic test_async_reset();
    total_money = 7'd20;
    cyc(1, 0, 0);
    wait_state(4);
    repeat (3) cyc(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    total++; if ({state, sec_left, play_en} !== {4'd0, 7'd0, 1'b0}) begin
      bad++; $display("FAIL async_reset: got %0d/%0d/%0d want 0/0/0", state, sec_left, play_en);
    end
    #3 rst = 1'b0;
    model_reset();
    cyc(1, 0, 0);
    total++; if ({state, ticket} !== {4'd1, 1'b1}) begin
      bad++; $display("FAIL reset_recharge: got %0d/%0d want 1/1", state, ticket);
    end
    cyc(0, 1, 0);
  endtask

  task automatic test_random();
    bit s, a, f;
    for (int i = 0; i < 3000; i++) begin
      total_money = 7'($urandom_range(0, 20));
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 59) == 0);
      f = ($urandom_range(0, 29) == 0);
      cyc(s, a, f);
      total++;
      if ({state, sec_left, ticket, level_start, play_en, no_funds} !== model_vec()) begin
        bad++; $display("FAIL random_cycle%0d: got %h want %h", i, {state, sec_left, ticket, level_start, play_en, no_funds}, model_vec());
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    start = 1'b0; abort = 1'b0; fail = 1'b0;
    total_money = 7'd20;
    model_reset();
    test_reset();
    test_start_ok();
    test_no_funds();
    test_full_run();
    test_fail_expire();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
